// File: rtl/enc164_pkg.sv
// Shared constants and helpers for the enc164 request encoder.
package enc164_pkg;

  localparam int unsigned N_DEF     = 16;
  localparam int unsigned IDX_W_DEF = 4;

  function automatic logic [N_DEF-1:0] onehot(input logic [IDX_W_DEF-1:0] idx);
    logic [N_DEF-1:0] m;
    m      = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/enc164_pend_if.sv
// Request capture and index output bundle for enc164_pend.
interface enc164_pend_if
  import enc164_pkg::*;
#(
  parameter int unsigned N = N_DEF
) ();

  localparam int unsigned IDX_W = $clog2(N);

  logic             en;
  logic [N-1:0]     req;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic [N-1:0]     pending;

  modport master (
    output en, req, out_ready,
    input  out_valid, out_idx, pending
  );

  modport slave (
    input  en, req, out_ready,
    output out_valid, out_idx, pending
  );

endinterface

// File: rtl/enc164_prio_sel.sv
// Combinational picker: first set bit of vec at or after base, wrapping N-1 -> 0.
module enc164_prio_sel
  import enc164_pkg::*;
#(
  parameter  int unsigned N     = N_DEF,
  localparam int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     vec,
  input  logic [IDX_W-1:0] base,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] w_pos;

  always_comb begin
    any   = 1'b0;
    idx   = '0;
    w_pos = '0;
    for (int unsigned i = 0; i < N; i++) begin
      // IDX_W-bit add wraps naturally because N is a power of two
      w_pos = base + IDX_W'(i);
      if (!any && vec[w_pos]) begin
        any = 1'b1;
        idx = w_pos;
      end
    end
  end

endmodule

// File: rtl/enc164_pend.sv
// Registered 16-to-4 pending-request encoder with valid/ready output stage.
// Define ENC164_ROUND_ROBIN_EN for rotating priority; default is lowest-index-first.
module enc164_pend
  import enc164_pkg::*;
#(
  parameter int unsigned N = N_DEF
) (
  input logic         clk,
  input logic         rst,
  enc164_pend_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(N);

  logic [N-1:0]     r_pending;
  logic             r_valid;
  logic [IDX_W-1:0] r_idx;

  logic             w_free;
  logic             w_any;
  logic             w_load;
  logic [IDX_W-1:0] w_sel;
  logic [IDX_W-1:0] w_base;
  logic [N-1:0]     w_mask;
  logic [N-1:0]     w_clr;
  logic [N-1:0]     w_set;

`ifdef ENC164_ROUND_ROBIN_EN
  logic [IDX_W-1:0] r_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_load) begin
      r_ptr <= w_sel + IDX_W'(1);
    end
  end

  assign w_base = r_ptr;
`else
  assign w_base = '0;
`endif

  enc164_prio_sel #(
    .N (N)
  ) u_sel (
    .vec  (r_pending),
    .base (w_base),
    .any  (w_any),
    .idx  (w_sel)
  );

  if (N == N_DEF) begin : g_pkg_mask
    assign w_mask = onehot(IDX_W_DEF'(w_sel));
  end else begin : g_shift_mask
    assign w_mask = N'(1) << w_sel;
  end

  assign w_free = !r_valid || bus.out_ready;
  assign w_load = w_free && w_any;
  assign w_clr  = w_load ? w_mask : '0;
  assign w_set  = bus.en ? bus.req : '0;

  // Set is OR'd after clear so a re-request on the granted bit keeps it pending
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= '0;
      r_valid   <= 1'b0;
      r_idx     <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_set;
      if (w_free) begin
        r_valid <= w_any;
        if (w_any) begin
          r_idx <= w_sel;
        end
      end
    end
  end

  assign bus.out_valid = r_valid;
  assign bus.out_idx   = r_idx;
  assign bus.pending   = r_pending;

endmodule
